// File: rtl/vga_fbscan_if.sv
// -----------------------------------------------------------------------------
// vga_fbscan_if
//   Pixel write bus from the fractal engine into the vga_fbscan framebuffer.
//   The engine (master) drives it; vga_fbscan (slave) samples it on clk.
//
//   Signals:
//     wr_en     write strobe (the engine's ready); there is no backpressure
//     wr_pixel  1-bit pixel value to store
//     wr_addr   linear address y*160+x; valid range 0..19199
// -----------------------------------------------------------------------------
interface vga_fbscan_if;
    logic        wr_en;
    logic        wr_pixel;
    logic [18:0] wr_addr;

    modport master (
        output wr_en,
        output wr_pixel,
        output wr_addr
    );

    modport slave (
        input wr_en,
        input wr_pixel,
        input wr_addr
    );
endinterface

// File: rtl/vga_fbscan.sv
// -----------------------------------------------------------------------------
// vga_fbscan
//   Captures 1-bit pixel writes (160x120 source image, address y*160+x) into
//   an on-chip framebuffer and scans it out as 640x480@60 VGA, each source
//   pixel upscaled 4x4. Also emits a one-cycle frame tick at the start of
//   vertical blanking so the parameter logic can update between frames.
//
//   Parameters:
//     FG_COLOR    RGB332 colour shown for a set pixel
//     BG_COLOR    RGB332 colour shown for a clear pixel
//
//   Ports:
//     clk         25 MHz pixel clock, rising edge
//     reset       synchronous, active high; restarts scan, keeps framebuffer
//     wr          write bus (slave side): wr_en / wr_pixel / wr_addr
//     hsync       horizontal sync, active low
//     vsync       vertical sync, active low
//     rgb         RGB332 colour, forced to 0 outside the visible area
//     frame_tick  one-cycle pulse for output position (h=0, v=480)
//
//   Pipeline: S0 counters -> S1 read address + delayed flags -> S2 RAM data
//   and registered sync/tick. Outputs lag the counter position by 2 cycles,
//   with sync, blanking and colour all on the same stage.
// -----------------------------------------------------------------------------
module vga_fbscan #(
    parameter logic [7:0] FG_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    vga_fbscan_if.slave        wr,
    output logic               hsync,
    output logic               vsync,
    output logic [7:0]         rgb,
    output logic               frame_tick
);

    // Horizontal timing (pixel clocks)
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_FIRST = 10'd656;
    localparam logic [9:0] H_SYNC_LAST  = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;

    // Vertical timing (lines)
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_FIRST = 10'd490;
    localparam logic [9:0] V_SYNC_LAST  = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam int unsigned FB_DEPTH = 19200;
    localparam logic [18:0] FB_LIMIT = 19'd19200;

    // ------------------------------------------------------------------
    // S0: raster counters
    // ------------------------------------------------------------------
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
                vcnt <= '0;
            end else begin
                vcnt <= vcnt + 10'd1;
            end
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // S0 decode of the current counter position
    logic        vis0;
    logic        hs0;
    logic        vs0;
    logic        tick0;
    logic [6:0]  src_row;
    logic [7:0]  src_col;
    logic [14:0] src_addr;
    logic [14:0] rd_addr0;

    always_comb begin
        vis0  = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
        hs0   = !((hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST));
        vs0   = !((vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST));
        tick0 = (hcnt == '0) && (vcnt == V_VISIBLE);

        // 4x4 upscale: drop the two LSBs of each counter. row*160 is built
        // as row*128 + row*32 so no multiplier is needed.
        src_row  = vcnt[8:2];
        src_col  = hcnt[9:2];
        src_addr = {1'b0, src_row, 7'b0}
                 + {3'b0, src_row, 5'b0}
                 + {7'b0, src_col};

        // Outside the visible area the address is parked at 0.
        rd_addr0 = vis0 ? src_addr : '0;
    end

    // ------------------------------------------------------------------
    // S1: registered read address and delayed flags
    // ------------------------------------------------------------------
    logic [14:0] rd_addr;
    logic        vis1;
    logic        hs1;
    logic        vs1;
    logic        tick1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            vis1    <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            tick1   <= 1'b0;
        end else begin
            rd_addr <= rd_addr0;
            vis1    <= vis0;
            hs1     <= hs0;
            vs1     <= vs0;
            tick1   <= tick0;
        end
    end

    // ------------------------------------------------------------------
    // Framebuffer: one write port, one synchronous read port. Both live in
    // the same clocked block, so a same-cycle write and read of one address
    // returns the old contents (read-first). No reset: contents survive it.
    // ------------------------------------------------------------------
    logic mem [FB_DEPTH];
    logic rd_bit;
    logic wr_ok;

    always_comb begin
        wr_ok = wr.wr_en && !reset && (wr.wr_addr < FB_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr.wr_addr[14:0]] <= wr.wr_pixel;
        end
        rd_bit <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // S2: registered sync/tick/visible aligned with the RAM read data
    // ------------------------------------------------------------------
    logic vis2;

    always_ff @(posedge clk) begin
        if (reset) begin
            vis2       <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vis2       <= vis1;
            hsync      <= hs1;
            vsync      <= vs1;
            frame_tick <= tick1;
        end
    end

    // Colour select off S2 registers; blanking overrides the RAM bit, which
    // also hides the undefined read data right after reset.
    always_comb begin
        if (vis2) begin
            rgb = rd_bit ? FG_COLOR : BG_COLOR;
        end else begin
            rgb = '0;
        end
    end

endmodule

// File: tb/tb_vga_fbscan.sv
// -----------------------------------------------------------------------------
// tb_vga_fbscan
//   Scoreboard bench for vga_fbscan. The stimulus process pushes expected
//   output values (tagged with the bench cycle at which they must appear)
//   into a time-ordered queue; the monitor samples the outputs on every
//   falling edge, pops due entries and compares.
//
//   Timeline (k = cycles since reset release, output for position (h,v)
//   appears at k = v*800 + h + 2):
//     frame 0 : fill framebuffer (bits 0, 161, 19199 set), out-of-range writes,
//               upscale/blanking/hsync checks, nonzero-pixel count rows 0..199
//     k=160300: one-cycle reset at (300,200), with a write to addr 0 attempted
//     frame A : preserved contents, same-address collision at (20,0), corner
//               pixels, vsync, frame_tick, full-frame nonzero-pixel count
//     frame B : next frame_tick exactly 420000 cycles later
// -----------------------------------------------------------------------------
module tb_vga_fbscan;

    localparam int K_RGB  = 0;
    localparam int K_HS   = 1;
    localparam int K_VS   = 2;
    localparam int K_TICK = 3;
    localparam int K_CNT  = 4;
    localparam int K_CLR  = 5;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb;
    logic       frame_tick;

    vga_fbscan_if wr_bus ();

    vga_fbscan #(
        .FG_COLOR(8'hFF),
        .BG_COLOR(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_bus),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb),
        .frame_tick(frame_tick)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   nz_cnt   = 0;
    int   end_cyc  = 2000000;

    // Insert keeping the queue ordered by cycle (stable for equal cycles).
    task automatic expect_at(input int c, input int kind, input int val, input string name);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard checker
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        int   act;
        if (rgb != 8'h00) nz_cnt = nz_cnt + 1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.kind == K_CLR) begin
                nz_cnt = 0;
            end else begin
                case (e.kind)
                    K_RGB:   act = int'(rgb);
                    K_HS:    act = int'(hsync);
                    K_VS:    act = int'(vsync);
                    K_TICK:  act = int'(frame_tick);
                    K_CNT:   act = nz_cnt;
                    default: act = -1;
                endcase
                n_checks = n_checks + 1;
                if (e.cyc != cyc) begin
                    $display("FAIL %s: sample slot cycle %0d missed (now %0d), required %0h",
                             e.name, e.cyc, cyc, e.val);
                end else if (act == e.val) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL %s @cycle %0d: got %0h, required %0h",
                             e.name, cyc, act, e.val);
                end
            end
        end
        if (cyc >= end_cyc) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.kind != K_CLR) begin
                    n_checks = n_checks + 1;
                    $display("FAIL %s: never sampled (slot %0d), required %0h",
                             e.name, e.cyc, e.val);
                end
            end
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        int r0;
        int r1;

        reset           = 1'b1;
        wr_bus.wr_en    = 1'b0;
        wr_bus.wr_pixel = 1'b0;
        wr_bus.wr_addr  = '0;

        // Outputs during the 3 reset cycles
        for (int c = 1; c <= 3; c++) begin
            expect_at(c, K_HS,   1, "rst_hsync");
            expect_at(c, K_VS,   1, "rst_vsync");
            expect_at(c, K_RGB,  0, "rst_rgb");
            expect_at(c, K_TICK, 0, "rst_tick");
        end

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        r0 = cyc;

        // Frame 0: latency, upscale mapping, blanking, hsync
        expect_at(r0 + 1,            K_RGB, 8'h00, "flush_k1");
        expect_at(r0 + 2,            K_RGB, 8'hFF, "px_0_0");
        expect_at(r0 + 2,            K_HS,  1,     "hs_0_0");
        expect_at(r0 + 2,            K_VS,  1,     "vs_0_0");
        expect_at(r0 + 2,            K_TICK, 0,    "tick_0_0");
        expect_at(r0 + 5,            K_RGB, 8'hFF, "px_3_0");
        expect_at(r0 + 6,            K_RGB, 8'h00, "px_4_0");
        expect_at(r0 + 642,          K_RGB, 8'h00, "blank_640_0");
        expect_at(r0 + 657,          K_HS,  1,     "hs_655_0");
        expect_at(r0 + 658,          K_HS,  0,     "hs_656_0");
        expect_at(r0 + 753,          K_HS,  0,     "hs_751_0");
        expect_at(r0 + 754,          K_HS,  1,     "hs_752_0");
        expect_at(r0 + 2402,         K_RGB, 8'hFF, "px_0_3");
        expect_at(r0 + 2405,         K_RGB, 8'hFF, "px_3_3");
        expect_at(r0 + 3201,         K_RGB, 8'h00, "blank_799_3");
        expect_at(r0 + 3202,         K_RGB, 8'h00, "px_0_4");
        expect_at(r0 + 3206,         K_RGB, 8'hFF, "px_4_4");
        expect_at(r0 + 3210,         K_RGB, 8'h00, "px_8_4");
        expect_at(r0 + 5609,         K_RGB, 8'hFF, "px_7_7");
        expect_at(r0 + 6410,         K_RGB, 8'h00, "px_8_8");
        expect_at(r0 + 80658,        K_HS,  0,     "hs_656_100");
        expect_at(r0 + 80754,        K_HS,  1,     "hs_752_100");
        expect_at(r0 + 1,            K_CLR, 0,     "clr0");
        expect_at(r0 + 160001,       K_CNT, 32,    "nz_rows0_199");

        // Fill the framebuffer ahead of the scan; only 0, 161, 19199 set.
        for (int k = 0; k < 19200; k++) begin
            wr_bus.wr_en    = 1'b1;
            wr_bus.wr_addr  = 19'(k);
            wr_bus.wr_pixel = (k == 0) || (k == 161) || (k == 19199);
            next_cycle();
        end
        // Out-of-range writes must be dropped without aliasing.
        wr_bus.wr_addr  = 19'd19200;
        wr_bus.wr_pixel = 1'b1;
        next_cycle();
        wr_bus.wr_addr  = 19'h7FFFF;
        next_cycle();
        wr_bus.wr_en    = 1'b0;
        wr_bus.wr_pixel = 1'b0;

        while (cyc < r0 + 160300) next_cycle();

        // One-cycle reset at (300,200); the write attempted here must be ignored.
        reset           = 1'b1;
        wr_bus.wr_en    = 1'b1;
        wr_bus.wr_addr  = 19'd0;
        wr_bus.wr_pixel = 1'b0;
        next_cycle();
        reset           = 1'b0;
        wr_bus.wr_en    = 1'b0;
        r1 = cyc;

        // Frame A
        expect_at(r1,                K_RGB, 8'h00, "mrst_rgb");
        expect_at(r1,                K_HS,  1,     "mrst_hsync");
        expect_at(r1 + 1,            K_RGB, 8'h00, "mrst_flush");
        expect_at(r1 + 2,            K_RGB, 8'hFF, "keep_0_0");
        expect_at(r1 + 22,           K_RGB, 8'h00, "collide_20_0");
        expect_at(r1 + 822,          K_RGB, 8'hFF, "collide_20_1");
        expect_at(r1 + 3206,         K_RGB, 8'hFF, "keep_4_4");
        expect_at(r1 + 380641,       K_RGB, 8'h00, "px_639_475");
        expect_at(r1 + 381438,       K_RGB, 8'hFF, "px_636_476");
        expect_at(r1 + 383837,       K_RGB, 8'h00, "px_635_479");
        expect_at(r1 + 383841,       K_RGB, 8'hFF, "px_639_479");
        expect_at(r1 + 383842,       K_RGB, 8'h00, "blank_640_479");
        expect_at(r1 + 384001,       K_TICK, 0,    "tickA_pre");
        expect_at(r1 + 384002,       K_TICK, 1,    "tickA");
        expect_at(r1 + 384002,       K_RGB, 8'h00, "blank_0_480");
        expect_at(r1 + 384003,       K_TICK, 0,    "tickA_post");
        expect_at(r1 + 392001,       K_VS,  1,     "vs_799_489");
        expect_at(r1 + 392002,       K_VS,  0,     "vs_0_490");
        expect_at(r1 + 392657,       K_HS,  1,     "hs_655_490");
        expect_at(r1 + 392658,       K_HS,  0,     "hs_656_490");
        expect_at(r1 + 393601,       K_VS,  0,     "vs_799_491");
        expect_at(r1 + 393602,       K_VS,  1,     "vs_0_492");
        expect_at(r1 + 1,            K_CLR, 0,     "clrA");
        expect_at(r1 + 420001,       K_CNT, 63,    "nz_frameA");
        // Frame B
        expect_at(r1 + 804001,       K_TICK, 0,    "tickB_pre");
        expect_at(r1 + 804002,       K_TICK, 1,    "tickB");
        expect_at(r1 + 804003,       K_TICK, 0,    "tickB_post");
        end_cyc = r1 + 804010;

        // Write addr 5 in the cycle S1 reads it for position (20,0).
        repeat (21) next_cycle();
        wr_bus.wr_en    = 1'b1;
        wr_bus.wr_addr  = 19'd5;
        wr_bus.wr_pixel = 1'b1;
        next_cycle();
        wr_bus.wr_en    = 1'b0;
        wr_bus.wr_pixel = 1'b0;
    end

endmodule
